// File: rtl/lcd_bus_driver_if.sv
// lcd_bus_driver_if -- request/handshake bundle for lcd_bus_driver.
//   start : request to transfer one byte (sampled only while idle)
//   rs    : register select for the request (0 command, 1 data)
//   data  : byte for the request
//   done  : one-cycle completion pulse
//   busy  : driver is not idle
// Modports: master (requester), slave (driver).
interface lcd_bus_driver_if;
  logic       start;
  logic       rs;
  logic [7:0] data;
  logic       done;
  logic       busy;

  modport master (output start, rs, data, input done, busy);
  modport slave  (input start, rs, data, output done, busy);
endinterface

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver -- HD44780 write-only bus sequencer.
// One accepted request walks IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> DONE
// with a single shared 17-bit down-counter timing every state.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req (slave)       : start/rs/data in, done/busy out
//   LCD_RS/RW/EN/DATA : HD44780 bus (RW tied low)
// Build option: define LCD_LONG_CMD_EN to give clear/home commands
// (rs=0, data 0x01..0x03) the LONG_CYC execution wait instead of EXEC_CYC.
module lcd_bus_driver #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int LONG_CYC  = 82000
) (
  input  logic              clk,
  input  logic              reset,
  lcd_bus_driver_if.slave   req,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic              LCD_EN,
  output logic [7:0]        LCD_DATA
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, DONE} state_t;

  // Reload values are N-1: a state is left on the edge that sees cnt==0,
  // so it lasts exactly N cycles.
  localparam logic [16:0] SETUP_LD = 17'(SETUP_CYC - 1);
  localparam logic [16:0] EN_LD    = 17'(EN_CYC - 1);
  localparam logic [16:0] HOLD_LD  = 17'(HOLD_CYC - 1);
  localparam logic [16:0] EXEC_LD  = 17'(EXEC_CYC - 1);
  localparam logic [16:0] LONG_LD  = 17'(LONG_CYC - 1);

  state_t      state, state_nxt;
  logic [16:0] cnt, cnt_nxt;
  logic [16:0] wait_ld;
  logic        latch;

`ifdef LCD_LONG_CMD_EN
  // Classified from the latched bus values, which are stable for the
  // whole transfer.
  logic is_long;
  assign is_long = !LCD_RS && (LCD_DATA[7:2] == 6'd0) && (LCD_DATA != 8'd0);
  assign wait_ld = is_long ? LONG_LD : EXEC_LD;
`else
  // Clear/home commands get no special treatment in this build.
  assign wait_ld = (LONG_LD == EXEC_LD) ? EXEC_LD : EXEC_LD;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != 17'd0) ? cnt - 17'd1 : cnt;
    latch     = 1'b0;
    case (state)
      IDLE:  if (req.start) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
               latch     = 1'b1;
             end
      SETUP: if (cnt == 17'd0) begin state_nxt = PULSE; cnt_nxt = EN_LD;   end
      PULSE: if (cnt == 17'd0) begin state_nxt = HOLD;  cnt_nxt = HOLD_LD; end
      HOLD:  if (cnt == 17'd0) begin state_nxt = WAIT;  cnt_nxt = wait_ld; end
      WAIT:  if (cnt == 17'd0) begin state_nxt = DONE;  cnt_nxt = 17'd0;   end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // EN and done are registered from the next state so both are glitch-free
  // and aligned with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 17'd0;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
      req.done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      LCD_EN   <= (state_nxt == PULSE);
      req.done <= (state_nxt == DONE);
      if (latch) begin
        LCD_RS   <= req.rs;
        LCD_DATA <= req.data;
      end
    end
  end

  assign req.busy = (state != IDLE);
  assign LCD_RW   = 1'b0;
endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver -- directed self-checking bench for lcd_bus_driver
// (default timing parameters). Edge 0 is the clock edge that samples start;
// a normal transfer shows EN high after edges 2..26 and done after edge 2029.
module tb_lcd_bus_driver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] LCD_DATA;
  int         checks = 0;
  int         errors = 0;

  lcd_bus_driver_if bus ();

  lcd_bus_driver dut (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.slave),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_DATA (LCD_DATA)
  );

  always #5 clk = ~clk;

`ifdef LCD_LONG_CMD_EN
  localparam int CLR_DONE = 82029;
`else
  localparam int CLR_DONE = 2029;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request; inj>0 pulses a second start (data 0x42) before edge inj.
  task automatic xfer(input string tag, input logic r, input logic [7:0] d,
                      input int exp_done, input int inj);
    int en_first, en_last, en_cnt, done_edge, done_cnt;
    en_first = -1; en_last = -1; en_cnt = 0; done_edge = -1; done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.rs = r; bus.data = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, " rs"},   int'(LCD_RS),   int'(r));
    chk({tag, " data"}, int'(LCD_DATA), int'(d));
    chk({tag, " busy"}, int'(bus.busy), 1);
    for (int k = 1; k <= exp_done + 2; k++) begin
      if (k == inj) begin bus.start = 1'b1; bus.rs = 1'b1; bus.data = 8'h42; end
      @(posedge clk); #1;
      if (k == inj) bus.start = 1'b0;
      if (LCD_EN) begin
        if (en_first < 0) en_first = k;
        en_last = k;
        en_cnt++;
      end
      if (bus.done) begin done_edge = k; done_cnt++; end
    end
    chk({tag, " en_first"},  en_first, 2);
    chk({tag, " en_last"},   en_last, 26);
    chk({tag, " en_cnt"},    en_cnt, 25);
    chk({tag, " done_edge"}, done_edge, exp_done);
    chk({tag, " done_cnt"},  done_cnt, 1);
    chk({tag, " busy_end"},  int'(bus.busy), 0);
    chk({tag, " data_end"},  int'(LCD_DATA), int'(d));
    chk({tag, " rw"},        int'(LCD_RW), 0);
  endtask

  initial begin
    int d1, d2, dcnt;
    bus.start = 1'b0; bus.rs = 1'b0; bus.data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst en",   int'(LCD_EN), 0);
    chk("rst rs",   int'(LCD_RS), 0);
    chk("rst rw",   int'(LCD_RW), 0);
    chk("rst data", int'(LCD_DATA), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    reset = 1'b0;

    xfer("data41", 1'b1, 8'h41, 2029, 0);
    xfer("clear01", 1'b0, 8'h01, CLR_DONE, 0);
    xfer("fset38", 1'b0, 8'h38, 2029, 0);
    xfer("ignore42", 1'b1, 8'h41, 2029, 5);

    // Reset while EN is high: everything drops before the next edge.
    @(negedge clk);
    bus.start = 1'b1; bus.rs = 1'b1; bus.data = 8'h41;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid en_high", int'(LCD_EN), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid en",   int'(LCD_EN), 0);
    chk("mid rs",   int'(LCD_RS), 0);
    chk("mid data", int'(LCD_DATA), 0);
    chk("mid busy", int'(bus.busy), 0);
    chk("mid done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    xfer("post_rst", 1'b1, 8'h41, 2029, 0);

    // Start held high: done pulses 2031 edges apart (DONE, one IDLE cycle,
    // then the next sampling edge).
    d1 = -1; d2 = -1; dcnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.rs = 1'b1; bus.data = 8'h55;
    for (int k = 0; k <= 4061; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dcnt++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
    end
    bus.start = 1'b0;
    chk("b2b first", d1, 2029);
    chk("b2b gap",   d2 - d1, 2031);
    chk("b2b cnt",   dcnt, 2);
    chk("b2b idle",  int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
